// File: rtl/seq_arb_rr_burst.sv
`default_nettype none
// ============================================================================
// Module      : seq_arb_rr_burst
// Description : N-input round-robin arbiter with a loadable one-hot priority
//               pointer and a burst lock that lets the current owner keep
//               the grant for up to MAX_BURST consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_arb_rr_burst #(
  parameter int NREQS     = 4,
  parameter int MAX_BURST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_priority_en,
  input  logic [NREQS-1:0] set_priority,
  input  logic [NREQS-1:0] reqs,
  output logic [NREQS-1:0] grants,
  output logic             locked
);

  localparam int IDX_W = (NREQS > 1) ? $clog2(NREQS) : 1;
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  // State
  logic [NREQS-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             owner_val_q, owner_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational helpers
  logic [IDX_W-1:0] w_prio_idx;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_found;
  logic             w_hold;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_granted;
  logic [NREQS-1:0] w_next_prio;
  logic [NREQS-1:0] w_sp_onehot;

  // Index of the highest-priority requester; lowest set bit wins so a
  // malformed pointer still resolves to a single position.
  always_comb begin
    w_prio_idx = '0;
    for (int i = NREQS - 1; i >= 0; i--) begin
      if (prio_q[i]) w_prio_idx = IDX_W'(i);
    end
  end

  // Scan requests from the priority position upward with wrap-around.
  always_comb begin
    int scan;
    scan        = 0;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 0; i < NREQS; i++) begin
      scan = (int'(w_prio_idx) + i) % NREQS;
      if (!w_arb_found && reqs[scan]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IDX_W'(scan);
      end
    end
  end

  // The owner keeps the grant while it still requests and has burst budget.
  assign w_hold = owner_val_q && reqs[owner_q] && (cnt_q < CNT_MAX);

  // Grant outputs: hold path first, otherwise the rotating scan.
  always_comb begin
    grants      = '0;
    locked      = 1'b0;
    w_grant_idx = '0;
    w_granted   = 1'b0;
    if (w_hold) begin
      grants[owner_q] = 1'b1;
      locked          = 1'b1;
      w_grant_idx     = owner_q;
      w_granted       = 1'b1;
    end else if (w_arb_found) begin
      grants[w_arb_idx] = 1'b1;
      w_grant_idx       = w_arb_idx;
      w_granted         = 1'b1;
    end
  end

  // Pointer after a grant moves to the requester just past the winner;
  // a loaded pointer is reduced to its lowest set bit (bit 0 if empty).
  always_comb begin
    int nxt;
    nxt         = (int'(w_grant_idx) + 1) % NREQS;
    w_next_prio = '0;
    w_next_prio[nxt] = 1'b1;
    w_sp_onehot = set_priority & (~set_priority + NREQS'(1));
    if (w_sp_onehot == '0) w_sp_onehot = NREQS'(1);
  end

  // Next-state selection: pointer load beats any grant-driven update.
  always_comb begin
    prio_d      = prio_q;
    owner_d     = owner_q;
    owner_val_d = owner_val_q;
    cnt_d       = cnt_q;
    if (set_priority_en) begin
      prio_d      = w_sp_onehot;
      owner_val_d = 1'b0;
      cnt_d       = '0;
    end else if (!w_granted) begin
      owner_val_d = 1'b0;
      cnt_d       = '0;
    end else if (w_hold) begin
      cnt_d  = cnt_q + CNT_W'(1);
      prio_d = w_next_prio;
    end else begin
      owner_d     = w_grant_idx;
      owner_val_d = 1'b1;
      cnt_d       = CNT_W'(1);
      prio_d      = w_next_prio;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= NREQS'(1);
      owner_q     <= '0;
      owner_val_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      owner_val_q <= owner_val_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_arb_rr_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_arb_rr_burst
// Description : Directed and randomised checks of seq_arb_rr_burst with
//               NREQS=4 and MAX_BURST=1..4 instantiated side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_arb_rr_burst;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_priority_en;
  logic [3:0] set_priority;
  logic [3:0] reqs;
  logic [3:0] g [1:4];
  logic       l [1:4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // One arbiter per burst length; instance k has MAX_BURST = k.
  for (genvar k = 1; k <= 4; k++) begin : g_dut
    seq_arb_rr_burst #(.NREQS(4), .MAX_BURST(k)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .set_priority_en(set_priority_en),
      .set_priority   (set_priority),
      .reqs           (reqs),
      .grants         (g[k]),
      .locked         (l[k])
    );
  end

  // Apply inputs shortly after a rising edge and let outputs settle.
  task automatic drive(input logic rst, input logic spe, input logic [3:0] sp,
                       input logic [3:0] r);
    reset = rst; set_priority_en = spe; set_priority = sp; reqs = r;
    #2;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 4'b0000, 4'b0000);
    next_cycle();
  endtask

  task automatic test_reset;
    do_reset();
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (g[k] !== 4'b0000 || l[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset mb%0d: grants=%b locked=%b expected 0000/0", k, g[k], l[k]);
      end
    end
    next_cycle();
  endtask

  task automatic test_plain_rr;
    logic [3:0] exp_g [0:3];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 4'b1111);
      n_checks++;
      if (g[1] !== exp_g[i] || l[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL plain_rr c%0d: grants=%b locked=%b expected %b/0", i, g[1], l[1], exp_g[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_burst2;
    logic [3:0] exp_g [0:4];
    logic       exp_l [0:4];
    exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 4'b1111);
      n_checks++;
      if (g[2] !== exp_g[i] || l[2] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL burst2 c%0d: grants=%b locked=%b expected %b/%b", i, g[2], l[2], exp_g[i], exp_l[i]);
      end
      next_cycle();
    end
  endtask

  // Pointer load, owner dropping its request, and wrap from 3 back to 0.
  task automatic test_prio_wrap;
    logic [3:0] r_v   [0:5];
    logic [3:0] exp_g [0:5];
    logic       exp_l [0:5];
    r_v   = '{4'b0000, 4'b1111, 4'b1011, 4'b1011, 4'b0011, 4'b0010};
    exp_g = '{4'b0000, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0010};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i == 0), 4'b0100, r_v[i]);
      n_checks++;
      if (g[2] !== exp_g[i] || l[2] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL prio_wrap c%0d: grants=%b locked=%b expected %b/%b", i, g[2], l[2], exp_g[i], exp_l[i]);
      end
      next_cycle();
    end
  endtask

  // Non-one-hot pointer picks its lowest bit; all-zero picks bit 0.
  task automatic test_prio_normalise;
    do_reset();
    drive(1'b0, 1'b1, 4'b0110, 4'b0000);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (g[1] !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_multi: grants=%b expected 0010", g[1]);
    end
    next_cycle();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (g[1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL prio_zero: grants=%b expected 0001", g[1]);
    end
    next_cycle();
  endtask

  task automatic test_sole_requester;
    logic exp_l [0:6];
    exp_l = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 4'b0001);
      n_checks++;
      if (g[3] !== 4'b0001 || l[3] !== exp_l[i]) begin
        n_fail++;
        $display("FAIL sole_req c%0d: grants=%b locked=%b expected 0001/%b", i, g[3], l[3], exp_l[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_burst_reset;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 4'b0000, 4'b1111);
      n_checks++;
      if (g[4] !== 4'b0001 || l[4] !== (i == 1)) begin
        n_fail++;
        $display("FAIL mid_reset pre c%0d: grants=%b locked=%b expected 0001/%0d", i, g[4], l[4], (i == 1));
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, 4'b0000, 4'b1111);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (g[4] !== 4'b0001 || l[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset post: grants=%b locked=%b expected 0001/0", g[4], l[4]);
    end
    next_cycle();
  endtask

  task automatic test_prio_during_lock;
    do_reset();
    drive(1'b0, 1'b0, 4'b0000, 4'b0010);
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (g[4] !== 4'b0010 || l[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_setup: grants=%b locked=%b expected 0010/1", g[4], l[4]);
    end
    next_cycle();
    drive(1'b0, 1'b1, 4'b1000, 4'b1111);
    n_checks++;
    if (g[4] !== 4'b0010 || l[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_setprio_same: grants=%b locked=%b expected 0010/1", g[4], l[4]);
    end
    next_cycle();
    drive(1'b0, 1'b0, 4'b0000, 4'b1111);
    n_checks++;
    if (g[4] !== 4'b1000 || l[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_setprio_next: grants=%b locked=%b expected 1000/0", g[4], l[4]);
    end
    next_cycle();
  endtask

  // Random stimulus against an independent behavioural model per instance.
  task automatic test_random;
    int   m_prio [1:4];
    int   m_owner[1:4];
    bit   m_oval [1:4];
    int   m_cnt  [1:4];
    logic [3:0] prev_g [1:4];
    bit   prev_ovr;
    int   run [1:4];
    logic [3:0] eg;
    logic el;
    int   gi;
    bit   found;
    bit   rst, spe;
    logic [3:0] sp, r;
    int   spi;
    prev_ovr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      m_prio[k] = 0; m_owner[k] = 0; m_oval[k] = 0; m_cnt[k] = 0;
      prev_g[k] = 4'b0000; run[k] = 0;
    end
    for (int c = 0; c < 200; c++) begin
      rst = (c == 0) || ($urandom_range(0, 31) == 0);
      spe = ($urandom_range(0, 7) == 0);
      sp  = 4'($urandom_range(0, 15));
      r   = 4'($urandom_range(0, 15));
      drive(rst, spe, sp, r);
      for (int k = 1; k <= 4; k++) begin
        eg = 4'b0000; el = 1'b0; gi = 0; found = 0;
        if (m_oval[k] && r[m_owner[k]] && m_cnt[k] < k) begin
          gi = m_owner[k]; found = 1; el = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) begin
            int j;
            j = (m_prio[k] + i) % 4;
            if (!found && r[j]) begin gi = j; found = 1; end
          end
        end
        if (found) eg[gi] = 1'b1;
        if (c > 0) begin
          n_checks++;
          if (g[k] !== eg || l[k] !== el) begin
            n_fail++;
            $display("FAIL rand mb%0d c%0d: reqs=%b grants=%b locked=%b expected %b/%b", k, c, r, g[k], l[k], eg, el);
          end
        end
        n_checks++;
        if (!$onehot0(g[k]) || (g[k] & ~r) != 4'b0000) begin
          n_fail++;
          $display("FAIL rand_legal mb%0d c%0d: reqs=%b grants=%b expected one-hot subset", k, c, r, g[k]);
        end
        if (g[k] != 4'b0000 && g[k] == prev_g[k] && !prev_ovr && (r & ~g[k]) != 4'b0000)
          run[k]++;
        else
          run[k] = (g[k] != 4'b0000) ? 1 : 0;
        n_checks++;
        if (run[k] > k) begin
          n_fail++;
          $display("FAIL rand_fair mb%0d c%0d: hold run=%0d expected <= %0d", k, c, run[k], k);
        end
        prev_g[k] = g[k];
        // model state update
        if (rst) begin
          m_prio[k] = 0; m_owner[k] = 0; m_oval[k] = 0; m_cnt[k] = 0;
        end else if (spe) begin
          spi = 0;
          for (int i = 3; i >= 0; i--) if (sp[i]) spi = i;
          m_prio[k] = spi; m_oval[k] = 0; m_cnt[k] = 0;
        end else if (!found) begin
          m_oval[k] = 0; m_cnt[k] = 0;
        end else if (el) begin
          m_cnt[k]++; m_prio[k] = (gi + 1) % 4;
        end else begin
          m_owner[k] = gi; m_oval[k] = 1; m_cnt[k] = 1; m_prio[k] = (gi + 1) % 4;
        end
      end
      prev_ovr = rst || spe;
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; set_priority_en = 1'b0; set_priority = 4'b0000; reqs = 4'b0000;
    @(posedge clk); #1;
    test_reset();
    test_plain_rr();
    test_burst2();
    test_prio_wrap();
    test_prio_normalise();
    test_sole_requester();
    test_mid_burst_reset();
    test_prio_during_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
